// File: rtl/fm_tx_modulator.sv
// fm_tx_modulator: bus-programmed FM transmitter.
//
// Software pushes 8-bit unsigned audio samples into a FIFO over the register
// bus. A sample-rate divider pops one sample every SAMPLE_DIV clocks while the
// transmitter is RUN/UNDERRUN. Each popped sample frequency-modulates a phase
// accumulator whose top bits drive a 1-bit I/Q pair and an 8-bit phase word.
//
// Ports:
//   clk, RSTn                 clock, asynchronous active-low reset
//   wraddr, wdata, wea        register write bus (write only when wea == 4'hf)
//   rdaddr, rdata             register read bus, rdata registered
//   tx_state                  00 IDLE, 01 RUN, 10 UNDERRUN
//   tx_i, tx_q, tx_phase      carrier outputs derived from the phase accumulator
//   TX_Low_Water_interrupt    one-clk pulse when a pop crosses half-full
//   TX_Underrun_interrupt     one-clk pulse when RUN hits an empty FIFO on a tick
//
// Build option: define FM_TX_PREEMPH_EN to add first-order pre-emphasis.
module fm_tx_modulator #(
  parameter int unsigned FM_ADDR_WIDTH = 13,
  parameter int unsigned FIFO_AW       = 6,
  parameter int unsigned PHASE_WIDTH   = 24,
  parameter int unsigned SAMPLE_DIV    = 250
) (
  input  logic                     clk,
  input  logic                     RSTn,
  input  logic [FM_ADDR_WIDTH-1:0] wraddr,
  input  logic [FM_ADDR_WIDTH-1:0] rdaddr,
  input  logic [31:0]              wdata,
  input  logic [3:0]               wea,
  output logic [31:0]              rdata,
  output logic [1:0]               tx_state,
  output logic                     tx_i,
  output logic                     tx_q,
  output logic [7:0]               tx_phase,
  output logic                     TX_Low_Water_interrupt,
  output logic                     TX_Underrun_interrupt
);

  localparam int unsigned Depth = 1 << FIFO_AW;
  localparam int unsigned LvlW  = FIFO_AW + 1;
  localparam int unsigned CntW  = $clog2(SAMPLE_DIV);
  localparam int unsigned PW    = PHASE_WIDTH;

  localparam logic [FM_ADDR_WIDTH-1:0] AddrCtrl    = FM_ADDR_WIDTH'(32'h010);
  localparam logic [FM_ADDR_WIDTH-1:0] AddrCarrier = FM_ADDR_WIDTH'(32'h014);
  localparam logic [FM_ADDR_WIDTH-1:0] AddrDev     = FM_ADDR_WIDTH'(32'h018);
  localparam logic [FM_ADDR_WIDTH-1:0] AddrAudio   = FM_ADDR_WIDTH'(32'h01C);
  localparam logic [FM_ADDR_WIDTH-1:0] AddrStatus  = FM_ADDR_WIDTH'(32'h020);
  localparam logic [LvlW-1:0]          LvlFull     = LvlW'(Depth);
  localparam logic [LvlW-1:0]          LvlLow      = LvlW'(Depth / 2);
  localparam logic [CntW-1:0]          CntLast     = CntW'(SAMPLE_DIV - 1);

  typedef enum logic [1:0] {
    StIdle     = 2'b00,
    StRun      = 2'b01,
    StUnderrun = 2'b10
  } tx_state_e;

  tx_state_e          state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]      carrier_q, phase_q, phase_d, fcw_q, fcw_d, fcw_next;
  logic [3:0]         dev_q;
  logic [7:0]         fifo_mem [Depth];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]    level_q, level_d;
  logic               ovf_q, unf_q, irq_low_q, irq_unf_q;
  logic [31:0]        rdata_q, rdata_d;

  // Bus decode
  logic wr_en, ctrl_wr, start_cmd, stop_cmd, clr_cmd, push_req;
  assign wr_en     = (wea == 4'hf);
  assign ctrl_wr   = wr_en && (wraddr == AddrCtrl);
  assign start_cmd = ctrl_wr && (wdata[7:4] == 4'b0001);
  assign stop_cmd  = ctrl_wr && (wdata[7:4] == 4'b0010);
  assign clr_cmd   = ctrl_wr && wdata[3];
  assign push_req  = wr_en && (wraddr == AddrAudio);

  // Stop flushes everything, so it suppresses a same-cycle push, pop and tick.
  logic active, fifo_full, fifo_empty, tick, push_ok, pop, underrun_evt, low_evt;
  assign active       = (state_q != StIdle);
  assign fifo_full    = (level_q == LvlFull);
  assign fifo_empty   = (level_q == '0);
  assign tick         = active && (cnt_q == CntLast) && !stop_cmd;
  assign push_ok      = push_req && !fifo_full && !stop_cmd;
  assign pop          = tick && !fifo_empty;
  assign underrun_evt = tick && (state_q == StRun) && fifo_empty;
  assign low_evt      = pop && !push_ok && (level_q == LvlLow);

  // Sample to signed offset: x - 128 is x with the MSB inverted, sign-extended.
  logic [7:0]        sample;
  logic signed [8:0] s_val, e_val;
  assign sample = pop ? fifo_mem[rd_ptr_q] : 8'h80;
  assign s_val  = {~sample[7], ~sample[7], sample[6:0]};

`ifdef FM_TX_PREEMPH_EN
  logic signed [8:0] s_prev_q;
  logic signed [9:0] pe_s, pe_diff, pe_half, pe_sum;
  always_comb begin
    pe_s    = {s_val[8], s_val};
    pe_diff = pe_s - {s_prev_q[8], s_prev_q};
    pe_half = pe_diff >>> 1;
    pe_sum  = pe_s + pe_half;
    if (pe_sum > 10'sd127) begin
      e_val = 9'sd127;
    end else if (pe_sum < -10'sd128) begin
      e_val = -9'sd128;
    end else begin
      e_val = pe_sum[8:0];
    end
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      s_prev_q <= '0;
    end else if (stop_cmd) begin
      s_prev_q <= '0;
    end else if (tick) begin
      s_prev_q <= s_val;
    end
  end
`else
  assign e_val = s_val;
`endif

  assign fcw_next = carrier_q + ({{(PW - 9){e_val[8]}}, e_val} << dev_q);

  always_comb begin
    state_d = state_q;
    if (stop_cmd) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:     if (start_cmd) state_d = StRun;
        StRun:      if (tick && fifo_empty) state_d = StUnderrun;
        StUnderrun: if (tick && !fifo_empty) state_d = StRun;
        default:    state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    fcw_d   = fcw_q;
    level_d = level_q;
    if (stop_cmd) begin
      cnt_d   = '0;
      phase_d = '0;
      fcw_d   = '0;
      level_d = '0;
    end else begin
      level_d = level_q + LvlW'(push_ok) - LvlW'(pop);
      if (active) begin
        cnt_d   = (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
        phase_d = phase_q + fcw_q;
      end else begin
        cnt_d   = '0;
        phase_d = '0;
      end
      if (tick) fcw_d = fcw_next;
    end
  end

  always_comb begin
    rdata_d = '0;
    if (rdaddr == AddrCarrier) begin
      rdata_d = 32'(carrier_q);
    end else if (rdaddr == AddrDev) begin
      rdata_d = {28'b0, dev_q};
    end else if (rdaddr == AddrStatus) begin
      rdata_d = {21'b0, state_q, ovf_q, unf_q, 7'(level_q)};
    end
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      phase_q   <= '0;
      fcw_q     <= '0;
      level_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      carrier_q <= '0;
      dev_q     <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      irq_low_q <= 1'b0;
      irq_unf_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      fcw_q     <= fcw_d;
      level_q   <= level_d;
      wr_ptr_q  <= stop_cmd ? '0 : wr_ptr_q + FIFO_AW'(push_ok);
      rd_ptr_q  <= stop_cmd ? '0 : rd_ptr_q + FIFO_AW'(pop);
      if (wr_en && wraddr == AddrCarrier) carrier_q <= wdata[PW-1:0];
      if (wr_en && wraddr == AddrDev) dev_q <= wdata[3:0];
      ovf_q     <= (ovf_q && !clr_cmd) || (push_req && fifo_full && !stop_cmd);
      unf_q     <= (unf_q && !clr_cmd) || underrun_evt;
      irq_low_q <= low_evt;
      irq_unf_q <= underrun_evt;
      rdata_q   <= rdata_d;
    end
  end

  // Sample storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= wdata[7:0];
  end

  logic unused_wdata;
  assign unused_wdata = ^wdata;

  assign rdata                  = rdata_q;
  assign tx_state               = state_q;
  assign tx_i                   = phase_q[PW-1];
  assign tx_q                   = phase_q[PW-1] ^ phase_q[PW-2];
  assign tx_phase               = phase_q[PW-1 -: 8];
  assign TX_Low_Water_interrupt = irq_low_q;
  assign TX_Underrun_interrupt  = irq_unf_q;

endmodule

// File: tb/tb_fm_tx_modulator.sv
// Testbench for fm_tx_modulator: directed scenarios followed by randomized bus
// traffic, checked every cycle against a queue-based behavioural model.
module tb_fm_tx_modulator;

  localparam int unsigned AW    = 13;
  localparam int unsigned FAW   = 6;
  localparam int unsigned PW    = 24;
  localparam int unsigned DIV   = 16;
  localparam int          DEPTH = 64;
  localparam longint      MASK  = (64'sd1 <<< PW) - 1;

  logic          clk = 1'b0;
  logic          RSTn = 1'b0;
  logic [AW-1:0] wraddr = '0;
  logic [AW-1:0] rdaddr = 13'h020;
  logic [31:0]   wdata = '0;
  logic [3:0]    wea = '0;
  logic [31:0]   rdata;
  logic [1:0]    tx_state;
  logic          tx_i, tx_q;
  logic [7:0]    tx_phase;
  logic          TX_Low_Water_interrupt, TX_Underrun_interrupt;

  always #5 clk = ~clk;

  fm_tx_modulator #(
    .FM_ADDR_WIDTH(AW),
    .FIFO_AW      (FAW),
    .PHASE_WIDTH  (PW),
    .SAMPLE_DIV   (DIV)
  ) dut (
    .clk                   (clk),
    .RSTn                  (RSTn),
    .wraddr                (wraddr),
    .rdaddr                (rdaddr),
    .wdata                 (wdata),
    .wea                   (wea),
    .rdata                 (rdata),
    .tx_state              (tx_state),
    .tx_i                  (tx_i),
    .tx_q                  (tx_q),
    .tx_phase              (tx_phase),
    .TX_Low_Water_interrupt(TX_Low_Water_interrupt),
    .TX_Underrun_interrupt (TX_Underrun_interrupt)
  );

  int vectors = 0;
  int miscompares = 0;
  bit started = 1'b0;
  int low_cnt = 0;

  task automatic chk(string name, longint act, longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_state = 0;      // 0 idle, 1 run, 2 underrun
  int          m_q[$];
  bit          m_ovf = 0, m_unf = 0, m_irq_low = 0, m_irq_unf = 0;
  longint      m_carrier = 0, m_fcw = 0, m_phase = 0;
  int          m_dev = 0;
  int          m_edges = 0;      // clocks spent active since start
  int          m_prev = 0;
  logic [31:0] m_rdata = '0;

  function automatic logic [31:0] m_status();
    return 32'(m_state * 512 + int'(m_ovf) * 256 + int'(m_unf) * 128 + m_q.size());
  endfunction

`ifdef FM_TX_PREEMPH_EN
  function automatic int floor_half(int d);
    return (d >= 0) ? d / 2 : -((1 - d) / 2);
  endfunction
`endif

  task automatic model_step();
    bit     wen, ctrl, start, stop, clr, push, active, tick, popped, full, push_ok;
    int     lvl, old_state, smp, s, e;
    longint np;
    wen       = (wea == 4'hf);
    ctrl      = wen && (wraddr == 13'h010);
    start     = ctrl && (wdata[7:4] == 4'h1);
    stop      = ctrl && (wdata[7:4] == 4'h2);
    clr       = ctrl && wdata[3];
    push      = wen && (wraddr == 13'h01C);
    lvl       = m_q.size();
    old_state = m_state;
    active    = (old_state != 0);
    tick      = active && ((m_edges % DIV) == DIV - 1) && !stop;
    full      = (lvl == DEPTH);
    push_ok   = push && !full && !stop;
    popped    = 0;

    case (rdaddr)
      13'h014: m_rdata = 32'(m_carrier);
      13'h018: m_rdata = 32'(m_dev);
      13'h020: m_rdata = m_status();
      default: m_rdata = 32'h0;
    endcase

    np = active ? ((m_phase + m_fcw) & MASK) : 0;
    m_irq_low = 0;
    m_irq_unf = 0;
    if (clr) begin
      m_ovf = 0;
      m_unf = 0;
    end
    if (push && full && !stop) m_ovf = 1;

    if (stop) begin
      m_q.delete();
      m_state = 0;
      m_phase = 0;
      m_fcw   = 0;
      m_edges = 0;
      m_prev  = 0;
    end else begin
      if (tick) begin
        if (lvl > 0) begin
          smp = m_q.pop_front();
          popped = 1;
        end else begin
          smp = 128;
        end
        if (old_state == 1 && !popped) begin
          m_state = 2;
          m_unf = 1;
          m_irq_unf = 1;
        end
        if (old_state == 2 && popped) m_state = 1;
        s = smp - 128;
        e = s;
`ifdef FM_TX_PREEMPH_EN
        e = s + floor_half(s - m_prev);
        if (e > 127) e = 127;
        if (e < -128) e = -128;
`endif
        m_prev = s;
        m_fcw = (m_carrier + longint'(e) * (longint'(1) << m_dev)) & MASK;
        if (popped && !push_ok && lvl == DEPTH / 2) m_irq_low = 1;
      end
      if (push_ok) m_q.push_back(int'(wdata[7:0]));
      if (old_state == 0 && start) m_state = 1;
      m_edges = active ? m_edges + 1 : 0;
      m_phase = np;
    end
    if (wen && wraddr == 13'h014) m_carrier = longint'(wdata) & MASK;
    if (wen && wraddr == 13'h018) m_dev = int'(wdata[3:0]);
  endtask

  always @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      m_state = 0; m_q.delete(); m_ovf = 0; m_unf = 0; m_irq_low = 0; m_irq_unf = 0;
      m_carrier = 0; m_fcw = 0; m_phase = 0; m_dev = 0; m_edges = 0; m_prev = 0;
      m_rdata = '0;
    end else begin
      model_step();
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("tx_state", tx_state, m_state);
      chk("tx_phase", tx_phase, (m_phase >> (PW - 8)) & 255);
      chk("tx_i", tx_i, (m_phase >> (PW - 1)) & 1);
      chk("tx_q", tx_q, ((m_phase >> (PW - 1)) ^ (m_phase >> (PW - 2))) & 1);
      chk("rdata", rdata, m_rdata);
      chk("irq_low", TX_Low_Water_interrupt, m_irq_low);
      chk("irq_unf", TX_Underrun_interrupt, m_irq_unf);
    end
    if (TX_Low_Water_interrupt) low_cnt++;
  end

  // ---------------- stimulus ----------------
  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_wr(logic [AW-1:0] a, logic [31:0] d);
    wraddr = a;
    wdata  = d;
    wea    = 4'hf;
    step(1);
    wea    = 4'h0;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    case ($urandom_range(0, 4))
      0: return 13'h014;
      1: return 13'h018;
      2, 3: return 13'h020;
      default: return 13'($urandom);
    endcase
  endfunction

  initial begin
    int unsigned r;
    bit found;
    step(3);
    RSTn = 1'b1;
    started = 1'b1;
    step(1);
    chk("reset_rdata_status", rdata, 0);
    chk("reset_tx_state", tx_state, 0);
    chk("reset_tx_iq", {tx_i, tx_q}, 0);

    // Carrier + deviation, one sample, steady phase ramp.
    bus_wr(13'h014, 32'h0010_0000);
    bus_wr(13'h018, 32'd4);
    bus_wr(13'h01C, 32'h90);
    bus_wr(13'h010, 32'h10);
    step(DIV);
    chk("fcw_after_first_tick", m_fcw, 24'h100100);
    step(8);
    chk("phase_8clk_model", m_phase, 24'h800800);
    chk("tx_phase_8clk", tx_phase, 8'h80);
    chk("tx_i_8clk", tx_i, 1);
    step(8);
    chk("tx_i_16clk", tx_i, 0);

    // Start with an empty FIFO -> underrun, then recover.
    bus_wr(13'h010, 32'h20);
    bus_wr(13'h010, 32'h10);
    step(DIV);
    chk("underrun_state", tx_state, 2);
    chk("underrun_irq", TX_Underrun_interrupt, 1);
    chk("underrun_fcw", m_fcw, 24'h100000);
    step(1);
    chk("underrun_irq_one_cycle", TX_Underrun_interrupt, 0);
    chk("underrun_status", rdata, 32'h480);
    bus_wr(13'h01C, 32'h70);
    step(DIV - 2);
    chk("recover_state", tx_state, 1);
    chk("recover_fcw", m_fcw, 24'h0FFF00);

    // Stop, clear flags.
    bus_wr(13'h010, 32'h20);
    bus_wr(13'h010, 32'h08);
    step(1);
    chk("cleared_status", rdata, 0);

    // Overfill then drain past half-full.
    for (int i = 0; i < 65; i++) bus_wr(13'h01C, 32'($urandom_range(0, 255)));
    step(1);
    chk("full_status", rdata, 32'h140);
    low_cnt = 0;
    bus_wr(13'h010, 32'h10);
    step(32 * DIV);
    chk("low_water_before", low_cnt, 0);
    step(DIV + 1);
    chk("low_water_once", low_cnt, 1);
    chk("level31_status", rdata, 32'h31F);
    step(3 * DIV);
    chk("low_water_still_once", low_cnt, 1);

    // Stop exactly on a tick edge.
    found = 0;
    for (int i = 0; i < 2 * DIV && !found; i++) begin
      if (m_state != 0 && (m_edges % DIV) == DIV - 1) found = 1;
      else step(1);
    end
    chk("tick_sync_found", found, 1);
    bus_wr(13'h010, 32'h20);
    chk("stop_tick_state", tx_state, 0);
    chk("stop_tick_phase", tx_phase, 0);
    chk("stop_tick_irqs", {TX_Low_Water_interrupt, TX_Underrun_interrupt}, 0);
    step(1);
    chk("stop_tick_status", rdata, 32'h100);
    bus_wr(13'h010, 32'h08);
    step(1);
    chk("clear_after_stop", rdata, 0);

    // Pre-emphasis saturation case.
    bus_wr(13'h014, 32'h0);
    bus_wr(13'h018, 32'h0);
    bus_wr(13'h01C, 32'h80);
    bus_wr(13'h01C, 32'hFF);
    bus_wr(13'h010, 32'h10);
    step(DIV);
    chk("pe_fcw_first", m_fcw, 0);
    step(DIV);
    chk("pe_fcw_second_ff", m_fcw, 127);
    bus_wr(13'h010, 32'h20);
    bus_wr(13'h01C, 32'h80);
    bus_wr(13'h01C, 32'hC0);
    bus_wr(13'h010, 32'h10);
    step(DIV);
    chk("pe_fcw_first_b", m_fcw, 0);
    step(DIV);
`ifdef FM_TX_PREEMPH_EN
    chk("pe_fcw_second_c0", m_fcw, 96);
`else
    chk("pe_fcw_second_c0", m_fcw, 64);
`endif
    bus_wr(13'h010, 32'h20);

    // Randomized bus traffic with occasional asynchronous resets.
    for (int c = 0; c < 2000; c++) begin
      r      = $urandom_range(0, 999);
      rdaddr = pick_addr();
      wea    = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'hf;
      wdata  = $urandom;
      wraddr = 13'h010;
      if (r < 5) begin
        wea  = 4'h0;
        RSTn = 1'b0;
        step(1);
        RSTn = 1'b1;
        continue;
      end else if (r < 80) begin
        wdata[7:4] = 4'h1;
        wdata[3]   = ($urandom_range(0, 3) == 0);
      end else if (r < 92) begin
        wdata[7:4] = 4'h2;
      end else if (r < 110) begin
        wdata[3] = 1'b1;
      end else if (r < 140) begin
        wraddr = 13'h014;
      end else if (r < 160) begin
        wraddr = 13'h018;
      end else if (r < 230) begin
        wraddr = 13'h01C;
      end else if (r < 260) begin
        wraddr = 13'($urandom);
      end else begin
        wea = 4'h0;
      end
      step(1);
    end
    wea = 4'h0;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
